// File: rtl/wb_burst_master.sv
// Wishbone burst master: accepts a read/write burst command and runs it as
// an incrementing burst (cti 010, final beat 111) with an ack timeout.
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   cmd_*                        command handshake (we, byte address, beat count)
//   wr_data/wr_valid/wr_ready    write-data stream, one word per write beat
//   rd_data/rd_valid             read-data stream, no backpressure
//   done/err                     one-cycle completion pulse, err on timeout
//   wb_*                         Wishbone master bus
module wb_burst_master #(
    parameter int unsigned AW = 26,
    parameter int unsigned DW = 32,
    parameter int unsigned BL = 9,
    parameter int unsigned TO = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [BL-1:0]     cmd_len,
    input  logic [DW-1:0]     wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i
);

    localparam int unsigned SW = DW / 8;
    // Timeout counter only needs to reach TO-1.
    localparam int unsigned TW = (TO < 2) ? 1 : $clog2(TO);

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        WFETCH,
        BEAT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_d;
    logic [DW-1:0]   dat_d;
    logic [BL-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   to_q, to_d;
    logic            err_d;
    logic            rdv_d;

    // Handshake readies decode the current state directly.
    assign cmd_ready = (state_q == IDLE)   && !wb_rst_i;
    assign wr_ready  = (state_q == WFETCH) && !wb_rst_i;

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = wb_addr_o;
        dat_d   = wb_dat_o;
        cnt_d   = cnt_q;
        to_d    = '0;
        err_d   = 1'b0;
        rdv_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d   = cmd_we;
                    addr_d = cmd_addr;
                    cnt_d  = cmd_len;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else if (cmd_we) begin
                        state_d = WFETCH;
                    end else begin
                        state_d = BEAT;
                    end
                end
            end
            WFETCH: begin
                if (wr_valid) begin
                    dat_d   = wr_data;
                    state_d = BEAT;
                end
            end
            BEAT: begin
                if (wb_ack_i) begin
                    cnt_d  = cnt_q - BL'(1);
                    addr_d = wb_addr_o + AW'(SW);
                    rdv_d  = !we_q;
                    if (cnt_q == BL'(1)) begin
                        state_d = DONE;
                    end else if (we_q) begin
                        state_d = WFETCH;
                    end
                end else if (to_q == TW'(TO - 1)) begin
                    // Slave never answered: abandon the remaining beats.
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; bus outputs are registered from the next state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            to_q      <= '0;
            wb_addr_o <= '0;
            wb_dat_o  <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_cti_o  <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            wb_addr_o <= addr_d;
            wb_dat_o  <= dat_d;
            wb_cyc_o  <= (state_d == WFETCH) || (state_d == BEAT);
            wb_stb_o  <= (state_d == BEAT);
            wb_we_o   <= (state_d == BEAT) && we_d;
            wb_sel_o  <= (state_d == BEAT) ? '1 : '0;
            if (state_d == BEAT) begin
                wb_cti_o <= (cnt_d == BL'(1)) ? CTI_EOB : CTI_INCR;
            end else begin
                wb_cti_o <= 3'b000;
            end
            rd_valid  <= rdv_d;
            if (rdv_d) begin
                rd_data <= wb_dat_i;
            end
            done      <= (state_d == DONE);
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: tests push expected bus beats, read
// words and completions into queues; a negedge monitor pops and compares.
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [25:0] cmd_addr = '0;
    logic [8:0]  cmd_len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [25:0] wb_addr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        wb_ack_i = 1'b0;
    logic [31:0] wb_dat_i = '0;

    logic        ack_en = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;

    typedef struct {
        logic [25:0] addr;
        logic [2:0]  cti;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    logic        done_q[$];

    wb_burst_master dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .done     (done),
        .err      (err),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_addr_o(wb_addr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_cti_o (wb_cti_o),
        .wb_ack_i (wb_ack_i),
        .wb_dat_i (wb_dat_i)
    );

    always #5 clk = ~clk;

    // Slave: zero-wait-state ack, read data = 0xD0000000 | address.
    always @(posedge clk) begin
        #1;
        wb_ack_i = wb_stb_o && ack_en;
        wb_dat_i = 32'hD000_0000 | 32'(wb_addr_o);
    end

    // Monitor: compare every bus beat, read word and completion pulse.
    always @(negedge clk) begin
        if (wb_stb_o && wb_ack_i) begin
            vectors++;
            if (beat_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat: unexpected ack at addr=%h cti=%b", wb_addr_o, wb_cti_o);
            end else begin
                beat_t e;
                e = beat_q.pop_front();
                if (wb_addr_o !== e.addr || wb_cti_o !== e.cti || wb_we_o !== e.we ||
                    wb_sel_o !== 4'hF || (e.we && wb_dat_o !== e.dat)) begin
                    miscompares++;
                    $display("FAIL beat: got addr=%h cti=%b we=%b sel=%h dat=%h, want addr=%h cti=%b we=%b sel=f dat=%h",
                             wb_addr_o, wb_cti_o, wb_we_o, wb_sel_o, wb_dat_o, e.addr, e.cti, e.we, e.dat);
                end
            end
        end
        if (rd_valid) begin
            vectors++;
            if (rd_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd: unexpected rd_valid data=%h", rd_data);
            end else begin
                logic [31:0] e;
                e = rd_q.pop_front();
                if (rd_data !== e) begin
                    miscompares++;
                    $display("FAIL rd: got %h want %h", rd_data, e);
                end
            end
        end
        if (done) begin
            vectors++;
            done_cnt++;
            if (done_q.size() == 0) begin
                miscompares++;
                $display("FAIL done: unexpected done pulse err=%b", err);
            end else begin
                logic e;
                e = done_q.pop_front();
                if (err !== e || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done: got err=%b cyc=%b stb=%b want err=%b cyc=0 stb=0",
                             err, wb_cyc_o, wb_stb_o, e);
                end
            end
        end else if (err) begin
            vectors++;
            miscompares++;
            $display("FAIL err: err pulsed without done");
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_beat(input logic [25:0] a, input logic [2:0] c, input logic w, input logic [31:0] d);
        beat_t b;
        b.addr = a;
        b.cti  = c;
        b.we   = w;
        b.dat  = d;
        beat_q.push_back(b);
    endtask

    task automatic send_cmd(input logic we, input logic [25:0] addr, input logic [8:0] len);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #2;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd_accept: cmd_ready=0 want 1 within 50 cycles");
        end
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL done_wait: done count=%0d want >%0d", done_cnt, d0);
        end
    endtask

    // Feed one write word when wr_ready shows, optionally stalling first.
    task automatic feed_word(input logic [31:0] d, input int stall);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wr_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL wr_ready: wr_ready=0 want 1 within 20 cycles");
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_cyc_stb", 128'({wb_cyc_o, wb_stb_o}), 128'(2'b10));
            @(posedge clk); #2;
        end
        wr_valid = 1'b1;
        wr_data  = d;
        @(posedge clk); #2;
        wr_valid = 1'b0;
    endtask

    initial begin
        int d0;
        int cnt;
        logic saw_cyc;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              128'({wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
                    rd_data, rd_valid, done, err, wr_ready, cmd_ready}), 128'(0));
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_reset", 128'(cmd_ready), 128'(1));

        // Read burst, 4 beats from 0x100
        push_beat(26'h100, 3'b010, 1'b0, 32'h0);
        push_beat(26'h104, 3'b010, 1'b0, 32'h0);
        push_beat(26'h108, 3'b010, 1'b0, 32'h0);
        push_beat(26'h10C, 3'b111, 1'b0, 32'h0);
        rd_q.push_back(32'hD000_0100);
        rd_q.push_back(32'hD000_0104);
        rd_q.push_back(32'hD000_0108);
        rd_q.push_back(32'hD000_010C);
        done_q.push_back(1'b0);
        d0 = done_cnt;
        send_cmd(1'b0, 26'h100, 9'd4);
        wait_done(d0);

        // Write burst, 3 beats from 0x200, 2-cycle stall before beat 2
        push_beat(26'h200, 3'b010, 1'b1, 32'h1111_AAAA);
        push_beat(26'h204, 3'b010, 1'b1, 32'h2222_BBBB);
        push_beat(26'h208, 3'b111, 1'b1, 32'h3333_CCCC);
        done_q.push_back(1'b0);
        d0 = done_cnt;
        send_cmd(1'b1, 26'h200, 9'd3);
        feed_word(32'h1111_AAAA, 0);
        feed_word(32'h2222_BBBB, 2);
        feed_word(32'h3333_CCCC, 0);
        wait_done(d0);

        // Address wrap at the top of the 26-bit space
        push_beat(26'h3FF_FFFC, 3'b010, 1'b0, 32'h0);
        push_beat(26'h000_0000, 3'b111, 1'b0, 32'h0);
        rd_q.push_back(32'hD3FF_FFFC);
        rd_q.push_back(32'hD000_0000);
        done_q.push_back(1'b0);
        d0 = done_cnt;
        send_cmd(1'b0, 26'h3FF_FFFC, 9'd2);
        wait_done(d0);

        // Timeout: slave never acks, stb must stay up exactly 255 cycles
        ack_en = 1'b0;
        done_q.push_back(1'b1);
        d0 = done_cnt;
        send_cmd(1'b0, 26'h300, 9'd2);
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (wb_stb_o) begin
                cnt++;
            end else if (cnt > 0) begin
                break;
            end
        end
        check("timeout_stb_cycles", 128'({cnt, wb_cyc_o}), 128'({32'd255, 1'b0}));
        wait_done(d0);
        ack_en = 1'b1;

        // Reset during beat 2 of 4
        push_beat(26'h500, 3'b010, 1'b0, 32'h0);
        push_beat(26'h504, 3'b010, 1'b0, 32'h0);
        rd_q.push_back(32'hD000_0500);
        send_cmd(1'b0, 26'h500, 9'd4);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("reset_midburst",
              128'({wb_cyc_o, wb_stb_o, done, err, rd_valid, cmd_ready}), 128'(6'b000001));
        repeat (5) @(posedge clk);

        // Null command, then a follow-up single-beat read
        done_q.push_back(1'b0);
        d0 = done_cnt;
        send_cmd(1'b0, 26'h80, 9'd0);
        saw_cyc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            saw_cyc = saw_cyc | wb_cyc_o;
        end
        check("null_no_cyc", 128'(saw_cyc), 128'(0));
        wait_done(d0);

        push_beat(26'h40, 3'b111, 1'b0, 32'h0);
        rd_q.push_back(32'hD000_0040);
        done_q.push_back(1'b0);
        d0 = done_cnt;
        send_cmd(1'b0, 26'h40, 9'd1);
        wait_done(d0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained",
              128'({32'(beat_q.size()), 32'(rd_q.size()), 32'(done_q.size())}), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter AW, default 26, meaning Wishbone byte-address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width; the byte-select width is DW/8.
REQ-003 SHALL have parameter BL, default 9, meaning burst-length field width.
REQ-004 SHALL have parameter TO, default 255, meaning ack-timeout cycles.
REQ-005 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_we (in, 1: 1=write, 0=read), cmd_addr (in, AW), cmd_len (in, BL, beats).
REQ-008 SHALL have ports wr_data (in, DW), wr_valid (in, 1), wr_ready (out, 1): the write-data stream.
REQ-009 SHALL have ports rd_data (out, DW), rd_valid (out, 1): the read-data stream, with no backpressure.
REQ-010 SHALL have ports done (out, 1) and err (out, 1): the command-completion pulses.
REQ-011 SHALL have Wishbone master ports: wb_cyc_o, wb_stb_o, wb_we_o (out, 1 each); wb_addr_o (out, AW); wb_dat_o (out, DW); wb_sel_o (out, DW/8); wb_cti_o (out, 3); wb_ack_i (in, 1); wb_dat_i (in, DW).

Function
REQ-012 SHALL implement states IDLE, WFETCH, BEAT, DONE; cmd_ready=1 only in IDLE.
REQ-013 SHALL, on cmd_valid&&cmd_ready in IDLE:
- latch cmd_we, cmd_addr and cmd_len into a beat counter;
- go to WFETCH if write, BEAT if read;
- assert wb_cyc_o from the next cycle.
REQ-014 SHALL treat cmd_len==0 as a null command: go IDLE->DONE with no bus cycle, cyc never asserted, err=0.
REQ-015 SHALL, in WFETCH, drive wr_ready=1 combinationally.
- When wr_valid=1: load wr_data into wb_dat_o, go to BEAT.
- Otherwise: hold wb_stb_o=0 and wb_cyc_o=1.
REQ-016 SHALL, in BEAT, drive wb_stb_o=1, wb_we_o=latched we, wb_sel_o=all ones, and wb_addr_o=current address.
REQ-017 SHALL set wb_cti_o=3'b111 on the final beat (counter==1), otherwise 3'b010.
REQ-018 SHALL, on wb_ack_i in BEAT:
- decrement the counter;
- advance the address by DW/8, wrapping modulo 2^AW;
- if last beat, go to DONE and drop cyc/stb on the next cycle;
- else go to WFETCH (write) or stay in BEAT (read).
REQ-019 SHALL, on a read ack, register wb_dat_i into rd_data with rd_valid=1 for exactly one cycle, with 1-cycle latency after the ack cycle.
REQ-020 SHALL ignore wb_ack_i whenever wb_stb_o=0.
REQ-021 SHALL run a timeout counter in BEAT that clears on each ack.
- If TO cycles elapse with stb=1 and no ack: drop cyc/stb, go to DONE, and pulse err together with done.
- Remaining beats are abandoned.
REQ-022 SHALL, in DONE, pulse done=1 for one cycle with cyc=stb=0, then return to IDLE.
REQ-023 SHALL ignore cmd_valid while cmd_ready=0; commands are never queued.
REQ-024 SHALL keep wb_addr_o, wb_dat_o and wb_we_o stable while wb_stb_o=1 and no ack is received.

Reset
REQ-025 SHALL, on wb_rst_i=1 at a clock edge, take the state to IDLE from any state, including mid-burst.
REQ-026 SHALL drive these outputs to reset values while in reset:
- wb_cyc_o, wb_stb_o, wb_we_o = 0;
- wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o, rd_data = 0;
- rd_valid, done, err, wr_ready = 0;
- cmd_ready = 0.
REQ-027 SHALL drive cmd_ready=1 in the first cycle after wb_rst_i deasserts.
REQ-028 SHALL NOT pulse done or err for a command aborted by reset.

Verification
REQ-029 Read burst: cmd_we=0, addr=0x100, len=4, slave acks every cycle:
- addresses 0x100, 0x104, 0x108, 0x10C;
- cti 010, 010, 010, 111;
- four rd_valid pulses carrying the slave data in order, then one done pulse.
REQ-030 Write burst with stalls: len=3, wr_valid low for 2 cycles before beat 2:
- stb low during the stall, cyc held high;
- wb_dat_o follows the wr_data order;
- done pulses after the third ack.
REQ-031 Address wrap: AW=26, addr=0x3FFFFFC, len=2 -> second beat address is 0x0000000.
REQ-032 Timeout: slave never acks, TO=255 -> cyc drops 255 cycles after stb rises, done=err=1 for one cycle, zero rd_valid pulses.
REQ-033 Reset mid-burst: assert wb_rst_i during beat 2 of 4 -> cyc=stb=0 the next cycle, no done/err, cmd_ready=1 after release.
REQ-034 Null command: len=0 -> done pulse, cyc never asserted, next command accepted.
